// File: rtl/pwm_peripheral.sv
// Drives the 16 user outputs as forced-low, forced-high or a shared 8-bit PWM waveform.
// The duty register is shadowed at each period boundary; enables act immediately.
module pwm_peripheral #(
  parameter int CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [7:0]    pwm_count;
  logic [7:0]    duty_shadow;
  logic [15:0]   en_out;
  logic [15:0]   en_pwm;
  logic          tick;
  logic          boundary;
  logic          pwm_high;

  assign en_out   = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign tick     = (prescaler == PRE_MAX);
  assign boundary = tick && (pwm_count == 8'hFF);
  // 0xFF is special-cased so full duty never drops low at count 255.
  assign pwm_high = (duty_shadow == 8'hFF) || (pwm_count < duty_shadow);

  // NOTE: every register clears asynchronously; state is updated with <= only so
  // all flops sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler    <= '0;
      pwm_count    <= 8'h00;
      duty_shadow  <= 8'h00;
      period_start <= 1'b0;
      out          <= 16'h0000;
    end else begin
      if (tick) begin
        prescaler <= '0;
        pwm_count <= pwm_count + 8'd1;
      end else begin
        prescaler <= prescaler + PW'(1);
      end
      if (boundary) duty_shadow <= pwm_duty_cycle;
      period_start <= boundary;
      out          <= en_out & (~en_pwm | {16{pwm_high}});
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral: measured period/high-time results are
// matched against spec-derived expectations queued on a scoreboard.
module tb_pwm_peripheral;

  localparam int CLK_DIV = 13;
  localparam int PERIOD  = 256 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string tag;
    int    val;
  } exp_t;
  exp_t sb_q[$];

  pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .out             (out),
    .period_start    (period_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input int got);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", got, -1);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, got, e.val);
    end
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    {en_reg_out_15_8, en_reg_out_7_0} = eo;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
  endtask

  task automatic wait_ps(input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (period_start) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check("ps_timeout", 0, 1);
  endtask

  // Starts at a sample where period_start is high; ends at the next one.
  task automatic measure(input int chg_k, input logic [7:0] chg_duty,
                         output int len, output int high, output int first,
                         output int contig, output int others);
    int last = 0;
    len = -1; high = 0; first = 0; others = 0;
    for (int k = 1; k <= PERIOD + 700; k++) begin
      @(negedge clk);
      if (out[0]) begin
        high++;
        if (first == 0) first = k;
        last = k;
      end
      if (out[15:1] != 15'h0) others++;
      if (k == chg_k) pwm_duty_cycle = chg_duty;
      if (period_start) begin
        len = k;
        break;
      end
    end
    contig = (high == 0 || (last - first + 1) == high) ? 1 : 0;
  endtask

  task automatic run_period(input int chg_k, input logic [7:0] chg_duty,
                            input int exp_high, input int exp_first);
    int len, high, first, contig, others;
    push_exp("period_len", PERIOD);
    push_exp("high_time", exp_high);
    push_exp("first_high", exp_first);
    push_exp("contiguous", 1);
    push_exp("others_low", 0);
    measure(chg_k, chg_duty, len, high, first, contig, others);
    pop_check(len);
    pop_check(high);
    pop_check(first);
    pop_check(contig);
    pop_check(others);
  endtask

  initial begin
    int edges, dev, low_bad, even_bad, pwm_bad, high9, len;
    bit seen;

    // Reset held with all inputs high.
    rst_n = 1'b0;
    set_en(16'hFFFF, 16'hFFFF);
    pwm_duty_cycle = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_out", out, 16'h0000);
    check("rst_ps", period_start, 0);

    // Release: static channels high after one edge, PWM channels low all first period.
    set_en(16'h00FF, 16'h000F);
    rst_n = 1'b1;
    push_exp("first_ps_edge", PERIOD);
    push_exp("first_period_dev", 0);
    edges = 0; dev = 0; seen = 1'b0;
    for (int i = 0; i < PERIOD + 100; i++) begin
      @(negedge clk);
      edges++;
      if (edges == 1) check("static_after_rst", out, 16'h00F0);
      else if (out != 16'h00F0) dev++;
      if (period_start) begin
        seen = 1'b1;
        break;
      end
    end
    pop_check(seen ? edges : -1);
    pop_check(dev);
    @(negedge clk);
    check("shadow_ff_applied", out, 16'h00FF);

    // Static mode.
    set_en(16'hFFFF, 16'h0000);
    @(negedge clk);
    check("static_all_on", out, 16'hFFFF);
    set_en(16'h00F0, 16'h0000);
    @(negedge clk);
    check("static_00f0", out, 16'h00F0);
    pwm_duty_cycle = 8'h00;
    wait_ps(PERIOD + 100);
    set_en(16'h00F0, 16'hFFFF);
    @(negedge clk);
    check("pwm_duty0_off", out, 16'h0000);

    // Duty 0x00 on channel 0 for three periods.
    set_en(16'h0001, 16'h0001);
    wait_ps(PERIOD + 100);
    for (int p = 0; p < 3; p++) run_period(-1, 8'h00, 0, 0);

    // Duty 0x80: new value lands at the next boundary.
    pwm_duty_cycle = 8'h80;
    wait_ps(PERIOD + 100);
    for (int p = 0; p < 2; p++) run_period(-1, 8'h00, 128 * CLK_DIV, 1);

    // Duty 0xFF: high across boundaries.
    pwm_duty_cycle = 8'hFF;
    wait_ps(PERIOD + 100);
    for (int p = 0; p < 2; p++) run_period(-1, 8'h00, PERIOD, 1);

    // Mid-period update 0x40 -> 0xC0 at pwm_count 10.
    pwm_duty_cycle = 8'h40;
    wait_ps(PERIOD + 100);
    run_period(10 * CLK_DIV + 5, 8'hC0, 64 * CLK_DIV, 1);
    run_period(-1, 8'h00, 192 * CLK_DIV, 1);

    // Mixed channels.
    set_en(16'hAAAA, 16'hFF00);
    pwm_duty_cycle = 8'h40;
    wait_ps(PERIOD + 100);
    push_exp("mixed_len", PERIOD);
    push_exp("mixed_low_static", 0);
    push_exp("mixed_even_zero", 0);
    push_exp("mixed_pwm_equal", 0);
    push_exp("mixed_high9", 64 * CLK_DIV);
    len = -1; low_bad = 0; even_bad = 0; pwm_bad = 0; high9 = 0;
    for (int k = 1; k <= PERIOD + 700; k++) begin
      @(negedge clk);
      if ((out & 16'h00FF) != 16'h00AA) low_bad++;
      if ((out & 16'h5555) != 16'h0000) even_bad++;
      if ((out & 16'hAA00) != 16'h0000 && (out & 16'hAA00) != 16'hAA00) pwm_bad++;
      if (out[9]) high9++;
      if (period_start) begin
        len = k;
        break;
      end
    end
    pop_check(len);
    pop_check(low_bad);
    pop_check(even_bad);
    pop_check(pwm_bad);
    pop_check(high9);

    // Asynchronous reset mid-period with outputs high.
    set_en(16'hFFFF, 16'h0000);
    repeat (20) @(negedge clk);
    check("pre_async_out", out, 16'hFFFF);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_out", out, 16'h0000);
    check("async_rst_ps", period_start, 0);
    check("sb_drained", sb_q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_peripheral.md
# pwm_peripheral

Consumes the five control registers written over SPI and drives the 16 user outputs. Each output is forced low, forced high, or driven by a shared 8-bit PWM waveform whose duty cycle comes from the SPI-written duty register. The block sits directly downstream of the SPI register file, in the same `clk` domain. Its inputs are already synchronous, so no input synchronisers are needed.

## Interface
Parameters:
- CLK_DIV, default 13, clk cycles per PWM count. Legal range is ≥1. At 10 MHz: 10e6/13/256 ≈ 3.0 kHz PWM.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- en_reg_out_7_0  in  8  output enable, bits 7:0
- en_reg_out_15_8  in  8  output enable, bits 15:8
- en_reg_pwm_7_0  in  8  PWM mode select, bits 7:0
- en_reg_pwm_15_8  in  8  PWM mode select, bits 15:8
- pwm_duty_cycle  in  8  duty cycle. 0x00 = 0 %, 0xFF = 100 %.
- out  out  16  user outputs (registered)
- period_start  out  1  one-cycle pulse at the start of each PWM period (registered)

## Operation
- Internal enables: en_out[15:0] = {en_reg_out_15_8, en_reg_out_7_0}; en_pwm[15:0] = {en_reg_pwm_15_8, en_reg_pwm_7_0}.
- Prescaler:
  - Counts 0..CLK_DIV-1, width $clog2(CLK_DIV), minimum 1 bit.
  - tick = (prescaler == CLK_DIV-1). On tick, the prescaler returns to 0.
  - If CLK_DIV = 1, tick is asserted every cycle.
- pwm_count (8 bits):
  - Increments on tick.
  - Wraps from 255 to 0. This wrap is the period boundary.
  - Period length = 256·CLK_DIV clk cycles.
- duty_shadow (8 bits):
  - Loads pwm_duty_cycle only on the boundary tick (pwm_count 255→0).
  - A duty change mid-period never alters the current period, so there are no runt pulses.
  - The enable registers are not shadowed. Enable changes act immediately.
- pwm_high = 1 if duty_shadow == 0xFF, else (pwm_count < duty_shadow).
  - High time = duty·CLK_DIV clk cycles, except 0xFF, which is high for the full period.
  - Duty 0x00 is never high.
- Per channel i, registered: out[i] <= en_out[i] & (~en_pwm[i] | pwm_high). Truth table:
  - en_out = 0 → 0
  - en_out = 1, en_pwm = 0 → 1
  - en_out = 1, en_pwm = 1 → PWM
- period_start is registered and equals 1 in the cycle after the boundary tick. This is the same cycle in which pwm_count = 0 and duty_shadow holds its new value.
- Reset values:
  - out = 0x0000, period_start = 0.
  - prescaler = 0, pwm_count = 0, duty_shadow = 0x00.

## Timing
- Every output changes exactly one clk after its causes change. The causes are en_out, en_pwm, pwm_count and duty_shadow.
- Static enable change: out reflects the new enables on the 1st rising edge after the input changes.
- Duty change: takes effect at the next period boundary. The new waveform appears on out one cycle after period_start's cycle begins, aligned with the pwm_count = 0 state.
- Simultaneous events:
  - If pwm_duty_cycle changes in the same cycle as the boundary tick, the new value is captured.
  - If an enable changes in the same cycle as a pwm_high transition, both are reflected together on the next edge.
- Reset asserted mid-period: out, period_start and all counters clear asynchronously.
- After reset release:
  - The first period runs with duty_shadow = 0x00, so PWM channels stay low.
  - The first period_start pulse occurs 256·CLK_DIV cycles after the first active edge.
  - Static-high channels go high one cycle after release.
- No handshake with the SPI block. Register values are sampled every cycle.

## Test plan
- Reset: hold rst_n = 0 with all inputs at 0xFF → out = 0x0000, period_start = 0. Assert rst_n mid-period with outputs high → out clears immediately, without waiting for a clock edge.
- Static mode: en_out = 0xFFFF, en_pwm = 0x0000 → out = 0xFFFF one cycle later. Then en_out = 0x00F0 → out = 0x00F0. Then en_pwm = 0xFFFF with duty 0x00 → out = 0x0000.
- Duty waveform (CLK_DIV = 13, duty 0x80, en_out = en_pwm = 0x0001):
  - Measure from the second period onward.
  - period_start pulses every 3328 cycles.
  - out[0] is high for 1664 cycles, starting one cycle after each period_start.
  - out[15:1] = 0.
- Extremes: duty 0x00 → out[0] stays low for 3 periods. Duty 0xFF → out[0] stays high continuously across the boundaries.
- Mid-period duty update: duty 0x40 in a period, changed to 0xC0 at count 10 → that period's high time = 832 cycles, the next period's = 2496 cycles.
- Mixed channels: en_out = 0xAAAA, en_pwm = 0xFF00, duty 0x40 →
  - Bits 1, 3, 5, 7 are constantly high.
  - Bits 9, 11, 13, 15 toggle with the PWM waveform.
  - All even bits are 0.
